// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, direct-mapped BTB with 2-bit counters,
// and the IF/ID pipeline register with redirect, stall and sticky halt.
module fetch_stage #(
    parameter int unsigned     PC_W      = 9,
    parameter int unsigned     INS_W     = 32,
    parameter int unsigned     BTB_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    output logic             id_valid,
    output logic [PC_W-1:0]  id_pc,
    output logic [INS_W-1:0] id_instr,
    output logic             id_pred_taken,
    output logic [PC_W-1:0]  id_pred_target,
    output logic             halted
);

    localparam int unsigned IDX   = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = PC_W - IDX - 2;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             halted_q, halted_d;
    logic             id_valid_q, id_valid_d;
    logic [PC_W-1:0]  id_pc_q, id_pc_d;
    logic [INS_W-1:0] id_instr_q, id_instr_d;
    logic             id_pred_taken_q, id_pred_taken_d;
    logic [PC_W-1:0]  id_pred_target_q, id_pred_target_d;

    logic             btb_valid_q  [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag_q    [BTB_DEPTH];
    logic [PC_W-1:0]  btb_target_q [BTB_DEPTH];
    logic [1:0]       btb_ctr_q    [BTB_DEPTH];

    logic [IDX-1:0]   look_idx, upd_idx;
    logic [TAG_W-1:0] look_tag, upd_tag;
    logic             look_hit, upd_hit, pred_taken;
    logic [PC_W-1:0]  pred_target, pc_next;

    // Lookup reads the array registers, so a same-cycle update is not yet visible.
    assign look_idx    = pc_q[IDX+1:2];
    assign look_tag    = pc_q[PC_W-1:IDX+2];
    assign look_hit    = btb_valid_q[look_idx] && (btb_tag_q[look_idx] == look_tag);
    assign pred_taken  = look_hit && btb_ctr_q[look_idx][1];
    assign pred_target = btb_target_q[look_idx];
    assign pc_next     = pred_taken ? pred_target : pc_q + PC_W'(4);

    assign upd_idx = upd_pc[IDX+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX+2];
    assign upd_hit = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);

    always_comb begin
        pc_d             = pc_q;
        halted_d         = halted_q;
        id_valid_d       = id_valid_q;
        id_pc_d          = id_pc_q;
        id_instr_d       = id_instr_q;
        id_pred_taken_d  = id_pred_taken_q;
        id_pred_target_d = id_pred_target_q;
        if (halted_q) begin
            // Frozen until reset; redirect and halt have no effect.
        end else if (redirect) begin
            pc_d             = redirect_pc;
            id_valid_d       = 1'b0;
            id_instr_d       = '0;
            id_pred_taken_d  = 1'b0;
            id_pred_target_d = '0;
        end else if (halt) begin
            halted_d         = 1'b1;
            id_valid_d       = 1'b0;
            id_instr_d       = '0;
            id_pred_taken_d  = 1'b0;
            id_pred_target_d = '0;
        end else if (!stall) begin
            pc_d             = pc_next;
            id_valid_d       = 1'b1;
            id_pc_d          = pc_q;
            id_instr_d       = imem_rdata;
            id_pred_taken_d  = pred_taken;
            id_pred_target_d = pred_taken ? pred_target : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            halted_q         <= 1'b0;
            id_valid_q       <= 1'b0;
            id_pc_q          <= '0;
            id_instr_q       <= '0;
            id_pred_taken_q  <= 1'b0;
            id_pred_target_q <= '0;
        end else begin
            pc_q             <= pc_d;
            halted_q         <= halted_d;
            id_valid_q       <= id_valid_d;
            id_pc_q          <= id_pc_d;
            id_instr_q       <= id_instr_d;
            id_pred_taken_q  <= id_pred_taken_d;
            id_pred_target_q <= id_pred_target_d;
        end
    end

    // Training runs independently of stall and halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid_q  <= '{default: 1'b0};
            btb_tag_q    <= '{default: '0};
            btb_target_q <= '{default: '0};
            btb_ctr_q    <= '{default: 2'b01};
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    btb_target_q[upd_idx] <= upd_target;
                    if (btb_ctr_q[upd_idx] != 2'b11) begin
                        btb_ctr_q[upd_idx] <= btb_ctr_q[upd_idx] + 2'b01;
                    end
                end else if (btb_ctr_q[upd_idx] != 2'b00) begin
                    btb_ctr_q[upd_idx] <= btb_ctr_q[upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                btb_valid_q[upd_idx]  <= 1'b1;
                btb_tag_q[upd_idx]    <= upd_tag;
                btb_target_q[upd_idx] <= upd_target;
                btb_ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

    assign imem_addr      = pc_q;
    assign halted         = halted_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_instr       = id_instr_q;
    assign id_pred_taken  = id_pred_taken_q;
    assign id_pred_target = id_pred_target_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: hand-computed vector table, directed
// reset/wrap sequences, then random traffic against a behavioural model.
module tb_fetch_stage;

    localparam int unsigned PC_W      = 9;
    localparam int unsigned INS_W     = 32;
    localparam int unsigned BTB_DEPTH = 8;
    localparam logic [8:0]  RESET_PC  = 9'h000;

    logic        clk = 1'b0;
    logic        reset, stall, halt, redirect, upd_valid, upd_taken;
    logic [8:0]  redirect_pc, upd_pc, upd_target;
    logic [8:0]  imem_addr, id_pc, id_pred_target;
    logic [31:0] imem_rdata, id_instr;
    logic        id_valid, id_pred_taken, halted;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] hash(input logic [8:0] a);
        return {7'h55, a, 7'h2A, ~a};
    endfunction

    assign imem_rdata = hash(imem_addr);

    fetch_stage #(
        .PC_W      (PC_W),
        .INS_W     (INS_W),
        .BTB_DEPTH (BTB_DEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .halt           (halt),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_pred_taken  (id_pred_taken),
        .id_pred_target (id_pred_target),
        .halted         (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic       st, ha, rd;
        logic [8:0] rpc;
        logic       uv;
        logic [8:0] upc;
        logic       ut;
        logic [8:0] utgt;
        logic [8:0] e_addr;
        logic       e_v;
        logic [8:0] e_pc;
        logic       e_pt;
        logic [8:0] e_tgt;
        logic       e_halted;
    } vec_t;

    function automatic vec_t vec(input logic st, ha, rd, input logic [8:0] rpc,
                                 input logic uv, input logic [8:0] upc, input logic ut,
                                 input logic [8:0] utgt, input logic [8:0] e_addr,
                                 input logic e_v, input logic [8:0] e_pc, input logic e_pt,
                                 input logic [8:0] e_tgt, input logic e_halted);
        vec_t r;
        r.st = st; r.ha = ha; r.rd = rd; r.rpc = rpc; r.uv = uv; r.upc = upc; r.ut = ut;
        r.utgt = utgt; r.e_addr = e_addr; r.e_v = e_v; r.e_pc = e_pc; r.e_pt = e_pt;
        r.e_tgt = e_tgt; r.e_halted = e_halted;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; halt = 0; redirect = 0; redirect_pc = '0;
        upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_target = '0;
    endtask

    // Behavioural reference: state kept as plain integers, BTB indexed arithmetically.
    int m_pc, m_idpc, m_instr, m_ptgt;
    bit m_halted, m_idv, m_pt, m_flush;
    bit m_bv   [BTB_DEPTH];
    int m_btag [BTB_DEPTH];
    int m_btgt [BTB_DEPTH];
    int m_bctr [BTB_DEPTH];

    task automatic model_step();
        int i, t, nxt, j, ut;
        bit pr;
        if (reset) begin
            m_pc = int'(RESET_PC); m_halted = 0; m_idv = 0; m_idpc = 0; m_instr = 0;
            m_pt = 0; m_ptgt = 0; m_flush = 1;
            for (int k = 0; k < BTB_DEPTH; k++) begin
                m_bv[k] = 0; m_bctr[k] = 1;
            end
            return;
        end
        i   = (m_pc / 4) % BTB_DEPTH;
        t   = m_pc / (4 * BTB_DEPTH);
        pr  = m_bv[i] && (m_btag[i] == t) && (m_bctr[i] >= 2);
        nxt = pr ? m_btgt[i] : (m_pc + 4) % (1 << PC_W);
        if (m_halted) begin
        end else if (redirect) begin
            m_pc = int'(redirect_pc); m_idv = 0; m_instr = 0; m_pt = 0; m_ptgt = 0;
            m_flush = 1;
        end else if (halt) begin
            m_halted = 1; m_idv = 0; m_flush = 0;
        end else if (!stall) begin
            m_idv = 1; m_idpc = m_pc; m_instr = int'(hash(9'(m_pc)));
            m_pt = pr; m_ptgt = pr ? m_btgt[i] : 0; m_pc = nxt;
        end
        if (upd_valid) begin
            j  = (int'(upd_pc) / 4) % BTB_DEPTH;
            ut = int'(upd_pc) / (4 * BTB_DEPTH);
            if (m_bv[j] && m_btag[j] == ut) begin
                if (upd_taken) begin
                    m_bctr[j] = (m_bctr[j] + 1 > 3) ? 3 : m_bctr[j] + 1;
                    m_btgt[j] = int'(upd_target);
                end else begin
                    m_bctr[j] = (m_bctr[j] - 1 < 0) ? 0 : m_bctr[j] - 1;
                end
            end else if (upd_taken) begin
                m_bv[j] = 1; m_btag[j] = ut; m_btgt[j] = int'(upd_target); m_bctr[j] = 2;
            end
        end
    endtask

    task automatic model_compare();
        check("rnd imem_addr", 32'(imem_addr), 32'(m_pc));
        check("rnd halted", 32'(halted), 32'(m_halted));
        check("rnd id_valid", 32'(id_valid), 32'(m_idv));
        if (m_idv) begin
            check("rnd id_pc", 32'(id_pc), 32'(m_idpc));
            check("rnd id_instr", id_instr, 32'(m_instr));
            check("rnd id_pred_taken", 32'(id_pred_taken), 32'(m_pt));
            check("rnd id_pred_target", 32'(id_pred_target), 32'(m_ptgt));
        end else if (m_flush) begin
            check("rnd flush id_instr", id_instr, 32'd0);
            check("rnd flush id_pred_taken", 32'(id_pred_taken), 32'd0);
            check("rnd flush id_pred_target", 32'(id_pred_target), 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " imem_addr"}, 32'(imem_addr), 32'(RESET_PC));
        check({tag, " id_valid"}, 32'(id_valid), 32'd0);
        check({tag, " id_pc"}, 32'(id_pc), 32'd0);
        check({tag, " id_instr"}, id_instr, 32'd0);
        check({tag, " id_pred_taken"}, 32'(id_pred_taken), 32'd0);
        check({tag, " id_pred_target"}, 32'(id_pred_target), 32'd0);
        check({tag, " halted"}, 32'(halted), 32'd0);
    endtask

    vec_t tbl[$];

    initial begin
        // st ha rd rpc    uv upc    ut utgt   | addr   v  id_pc  pt tgt    halted
        tbl.push_back(vec(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h004, 1, 9'h000, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 1, 9'h010, 1, 9'h040, 9'h008, 1, 9'h004, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h00C, 1, 9'h008, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h010, 1, 9'h00C, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h040, 1, 9'h010, 1, 9'h040, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h044, 1, 9'h040, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 1, 9'h010, 1, 9'h010, 0, 9'h000, 9'h010, 0, 9'h000, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h014, 1, 9'h010, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 1, 9'h010, 1, 9'h040, 9'h018, 1, 9'h014, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 1, 9'h010, 1, 9'h040, 9'h01C, 1, 9'h018, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 1, 9'h010, 0, 9'h000, 9'h020, 1, 9'h01C, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 1, 9'h010, 0, 9'h000, 0, 9'h000, 9'h010, 0, 9'h000, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h040, 1, 9'h010, 1, 9'h040, 0));
        tbl.push_back(vec(0, 0, 1, 9'h030, 0, 9'h000, 0, 9'h000, 9'h030, 0, 9'h000, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h034, 1, 9'h030, 0, 9'h000, 0));
        tbl.push_back(vec(1, 0, 1, 9'h100, 0, 9'h000, 0, 9'h000, 9'h100, 0, 9'h000, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h104, 1, 9'h100, 0, 9'h000, 0));
        tbl.push_back(vec(1, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h104, 1, 9'h100, 0, 9'h000, 0));
        tbl.push_back(vec(1, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h104, 1, 9'h100, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h108, 1, 9'h104, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 1, 9'h108, 1, 9'h080, 9'h10C, 1, 9'h108, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 1, 9'h108, 0, 9'h000, 0, 9'h000, 9'h108, 0, 9'h000, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h080, 1, 9'h108, 1, 9'h080, 0));
        tbl.push_back(vec(0, 0, 1, 9'h020, 0, 9'h000, 0, 9'h000, 9'h020, 0, 9'h000, 0, 9'h000, 0));
        tbl.push_back(vec(0, 1, 1, 9'h0A0, 0, 9'h000, 0, 9'h000, 9'h0A0, 0, 9'h000, 0, 9'h000, 0));
        tbl.push_back(vec(0, 0, 1, 9'h020, 0, 9'h000, 0, 9'h000, 9'h020, 0, 9'h000, 0, 9'h000, 0));
        tbl.push_back(vec(0, 1, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h020, 0, 9'h000, 0, 9'h000, 1));
        tbl.push_back(vec(0, 0, 1, 9'h100, 0, 9'h000, 0, 9'h000, 9'h020, 0, 9'h000, 0, 9'h000, 1));
        tbl.push_back(vec(0, 1, 0, 9'h000, 0, 9'h000, 0, 9'h000, 9'h020, 0, 9'h000, 0, 9'h000, 1));
        tbl.push_back(vec(0, 0, 0, 9'h000, 1, 9'h020, 1, 9'h0C0, 9'h020, 0, 9'h000, 0, 9'h000, 1));

        idle_inputs();
        reset = 1;
        repeat (2) step();
        check_reset_state("reset");
        reset = 0;

        foreach (tbl[n]) begin
            stall = tbl[n].st; halt = tbl[n].ha; redirect = tbl[n].rd;
            redirect_pc = tbl[n].rpc; upd_valid = tbl[n].uv; upd_pc = tbl[n].upc;
            upd_taken = tbl[n].ut; upd_target = tbl[n].utgt;
            step();
            check($sformatf("vec%0d imem_addr", n), 32'(imem_addr), 32'(tbl[n].e_addr));
            check($sformatf("vec%0d id_valid", n), 32'(id_valid), 32'(tbl[n].e_v));
            check($sformatf("vec%0d halted", n), 32'(halted), 32'(tbl[n].e_halted));
            if (tbl[n].e_v) begin
                check($sformatf("vec%0d id_pc", n), 32'(id_pc), 32'(tbl[n].e_pc));
                check($sformatf("vec%0d id_instr", n), id_instr, hash(tbl[n].e_pc));
                check($sformatf("vec%0d id_pred_taken", n), 32'(id_pred_taken),
                      32'(tbl[n].e_pt));
                check($sformatf("vec%0d id_pred_target", n), 32'(id_pred_target),
                      32'(tbl[n].e_tgt));
            end else if (tbl[n].rd && !tbl[n].e_halted) begin
                check($sformatf("vec%0d flush id_instr", n), id_instr, 32'd0);
                check($sformatf("vec%0d flush id_pred_taken", n), 32'(id_pred_taken), 32'd0);
            end
        end

        // Reset releases halt and clears the BTB.
        idle_inputs();
        reset = 1;
        step();
        check_reset_state("unhalt reset");
        reset = 0;
        redirect = 1; redirect_pc = 9'h010;
        step();
        redirect = 0;
        step();
        check("btb cleared imem_addr", 32'(imem_addr), 32'h014);
        check("btb cleared pred", 32'(id_pred_taken), 32'd0);

        // PC+4 wraps at the top of the address space.
        redirect = 1; redirect_pc = 9'h1F8;
        step();
        redirect = 0;
        step();
        check("wrap imem_addr 1fc", 32'(imem_addr), 32'h1FC);
        step();
        check("wrap imem_addr 000", 32'(imem_addr), 32'h000);
        check("wrap id_pc", 32'(id_pc), 32'h1FC);

        // Random traffic against the model.
        reset = 1;
        model_step();
        step();
        reset = 0;
        model_compare();
        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom % 300 == 0) || (m_halted && ($urandom % 25 == 0));
            stall       = ($urandom % 5 == 0);
            halt        = ($urandom % 80 == 0);
            redirect    = ($urandom % 12 == 0);
            redirect_pc = {7'($urandom % 128), 2'b00};
            upd_valid   = ($urandom % 3 == 0);
            upd_pc      = 9'(($urandom % 24) * 4);
            upd_taken   = 1'($urandom % 2);
            upd_target  = {7'($urandom % 128), 2'b00};
            model_step();
            step();
            model_compare();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
